s2mm_writer: RTL and testbench

Stream-to-memory write engine: accepts a command (start word address, length in words), then drains a valid/ready input stream into a simple memory write port, one word per address. It is the write-direction counterpart of the MM2S read path: the stream side is the consumer end of the same handshake our skid buffers produce. It reports completion with a one-cycle done pulse carrying the beat count and a short-packet flag.

---
 rtl/s2mm_writer.sv | 138 +++++++++++++
 tb/tb_s2mm_writer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_writer.sv
// s2mm_writer: drains a valid/ready word stream into a memory write port starting
// at a commanded word address, then pulses done with the beat count and short flag.
module s2mm_writer #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_wvalid,
  input  logic                  o_wready,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [WORD_WIDTH-1:0] o_wdata,
  output logic                  o_done,
  output logic [LEN_WIDTH-1:0]  o_count,
  output logic                  o_short
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  cmd_fire;
  logic                  beat_fire;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  count;
  logic                  short_r;

  // A beat ends the transfer when it is the last word owed or the packet ends early.
  function automatic logic is_terminal(input logic last, input logic [LEN_WIDTH-1:0] rem);
    return last || (rem == LEN_WIDTH'(1));
  endfunction

  function automatic logic is_short(input logic last, input logic [LEN_WIDTH-1:0] rem);
    return last && (rem > LEN_WIDTH'(1));
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    i_ready    = 1'b0;
    cmd_fire   = 1'b0;
    beat_fire  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_fire   = 1'b1;
          state_next = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Output register can take a new beat when empty or being emptied this cycle.
        i_ready   = !o_wvalid || o_wready;
        beat_fire = i_valid && (!o_wvalid || o_wready);
        if (beat_fire && is_terminal(i_last, remaining)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!o_wvalid || o_wready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign wr_fire = o_wvalid && o_wready;
  assign o_done  = (state == DONE);

  // Write output register and completion status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_wvalid <= 1'b0;
      o_waddr  <= '0;
      o_wdata  <= '0;
      o_count  <= '0;
      o_short  <= 1'b0;
    end else begin
      if (beat_fire) begin
        o_wvalid <= 1'b1;
        o_waddr  <= cur_addr;
        o_wdata  <= i_data;
      end else if (wr_fire) begin
        o_wvalid <= 1'b0;
      end
      if ((state_next == DONE) && (state != DONE)) begin
        o_count <= cmd_fire ? '0 : count;
        o_short <= cmd_fire ? 1'b0 : short_r;
      end
    end
  end

  // Transfer bookkeeping; always loaded by a command before it is consulted
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      cur_addr  <= cmd_addr;
      remaining <= cmd_len;
      count     <= '0;
      short_r   <= 1'b0;
    end else if (beat_fire) begin
      cur_addr  <= cur_addr + ADDR_WIDTH'(1);
      remaining <= remaining - LEN_WIDTH'(1);
      count     <= count + LEN_WIDTH'(1);
      short_r   <= is_short(i_last, remaining);
    end
  end

endmodule

// File: tb/tb_s2mm_writer.sv
// Directed bench for s2mm_writer: a transaction-level model predicts every memory
// write and every done report; a compare process checks the DUT each cycle.
`timescale 1ns/1ps
module tb_s2mm_writer;
  localparam int WW = 8;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          i_valid;
  logic          i_ready;
  logic [WW-1:0] i_data;
  logic          i_last;
  logic          o_wvalid;
  logic          o_wready;
  logic [AW-1:0] o_waddr;
  logic [WW-1:0] o_wdata;
  logic          o_done;
  logic [LW-1:0] o_count;
  logic          o_short;

  typedef struct { logic [WW-1:0] data; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [WW-1:0] data; } wr_t;
  typedef struct { logic [LW-1:0] count; logic short_f; } done_t;

  beat_t         stream_q[$];
  wr_t           exp_w[$];
  done_t         exp_d[$];
  logic [AW-1:0] wlog_a[$];
  logic [WW-1:0] wlog_d[$];
  int            wlog_c[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_req = 0;

  s2mm_writer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_done(o_done), .o_count(o_count), .o_short(o_short)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic push_beat(input logic [WW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    stream_q.push_back(b);
  endtask

  task automatic clear_log();
    wlog_a.delete();
    wlog_d.delete();
    wlog_c.delete();
  endtask

  // Transaction model: take beats in order until len words or an i_last beat.
  task automatic model_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int    n = 0;
    int    lenv = int'(len);
    logic  sh = 1'b0;
    wr_t   w;
    done_t d;
    for (int k = 0; k < lenv && k < stream_q.size(); k++) begin
      w.addr = addr + AW'(k);
      w.data = stream_q[k].data;
      exp_w.push_back(w);
      n++;
      if (stream_q[k].last) begin
        sh = (n < lenv);
        break;
      end
    end
    d.count   = LW'(n);
    d.short_f = sh;
    exp_d.push_back(d);
  endtask

  task automatic issue_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len, input bit hold);
    int n = 0;
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    while (!cmd_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    model_cmd(addr, len);
    tick();
    if (hold) begin
      cmd_len  = '0;
      cmd_addr = 32'hDEAD_BEEF;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    dc = -1;
    while (n < 100) begin
      if (o_done) begin
        dc = cyc;
        break;
      end
      tick();
      n++;
    end
    check("done_seen", o_done, 1);
  endtask

  // Stream source: present the head beat, pop it once the handshake is certain.
  initial begin
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) stream_q.delete();
      if (stream_q.size() > 0) begin
        i_valid = 1'b1;
        i_data  = stream_q[0].data;
        i_last  = stream_q[0].last;
      end else begin
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
      end
      #1;
      if (i_valid && i_ready) void'(stream_q.pop_front());
    end
  end

  // Memory sink: ready by default; on request, stall 3 cycles after the next write.
  initial begin
    int sink_wr = 0;
    int stall_ack = 0;
    int armed_at = 0;
    int stall_left = 0;
    o_wready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_req != stall_ack) begin
        stall_ack  = stall_req;
        armed_at   = sink_wr + 1;
        stall_left = 3;
      end
      if (stall_left > 0 && sink_wr >= armed_at) begin
        o_wready = 1'b0;
        stall_left--;
      end else begin
        o_wready = 1'b1;
      end
      #1;
      if (o_wvalid && o_wready) sink_wr++;
    end
  end

  // Compare process
  initial begin
    bit            held = 1'b0;
    bit            prev_done = 1'b0;
    logic [AW-1:0] ha = '0;
    logic [WW-1:0] hd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        held = 1'b0;
        prev_done = 1'b0;
        exp_w.delete();
        exp_d.delete();
        continue;
      end
      if (held) begin
        check("stall_hold_valid", o_wvalid, 1);
        check("stall_hold_addr", o_waddr, ha);
        check("stall_hold_data", o_wdata, hd);
      end
      held = 1'b0;
      if (o_wvalid && !o_wready) begin
        check("stall_i_ready", i_ready, 0);
        held = 1'b1;
        ha = o_waddr;
        hd = o_wdata;
      end
      if (o_wvalid && o_wready) begin
        check("write_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          check("write_addr", o_waddr, exp_w[0].addr);
          check("write_data", o_wdata, exp_w[0].data);
          void'(exp_w.pop_front());
        end
        wlog_a.push_back(o_waddr);
        wlog_d.push_back(o_wdata);
        wlog_c.push_back(cyc);
      end
      if (o_done) begin
        check("done_single_cycle", prev_done, 0);
        check("done_expected", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) begin
          check("done_count", o_count, exp_d[0].count);
          check("done_short", o_short, exp_d[0].short_f);
          void'(exp_d.pop_front());
        end
      end
      prev_done = o_done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int n;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    #2 reset_n = 1'b0;
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_i_ready", i_ready, 0);
    check("rst_o_wvalid", o_wvalid, 0);
    check("rst_o_waddr", o_waddr, 0);
    check("rst_o_wdata", o_wdata, 0);
    check("rst_o_done", o_done, 0);
    check("rst_o_count", o_count, 0);
    check("rst_o_short", o_short, 0);
    reset_n = 1'b1;

    // Continuous stream, memory always ready
    clear_log();
    push_beat(8'hA1, 0); push_beat(8'hA2, 0); push_beat(8'hA3, 0); push_beat(8'hA4, 1);
    issue_cmd(32'h100, 16'd4, 0);
    wait_done(dc);
    check("t1_count", o_count, 4);
    check("t1_short", o_short, 0);
    check("t1_cmd_ready_in_done", cmd_ready, 0);
    check("t1_nwrites", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      check("t1_addr0", wlog_a[0], 32'h100);
      check("t1_addr3", wlog_a[3], 32'h103);
      check("t1_data0", wlog_d[0], 8'hA1);
      check("t1_data3", wlog_d[3], 8'hA4);
      check("t1_back_to_back", wlog_c[3] - wlog_c[0], 3);
      check("t1_done_latency", dc - wlog_c[3], 1);
    end
    tick();
    check("t1_cmd_ready_after", cmd_ready, 1);
    check("t1_count_held", o_count, 4);

    // Memory stall of 3 cycles after the first write
    clear_log();
    push_beat(8'hA1, 0); push_beat(8'hA2, 0); push_beat(8'hA3, 0); push_beat(8'hA4, 1);
    stall_req++;
    issue_cmd(32'h100, 16'd4, 0);
    wait_done(dc);
    check("t2_count", o_count, 4);
    check("t2_nwrites", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      check("t2_stall_gap", wlog_c[1] - wlog_c[0], 4);
      check("t2_data1", wlog_d[1], 8'hA2);
      check("t2_data3", wlog_d[3], 8'hA4);
      check("t2_addr1", wlog_a[1], 32'h101);
    end

    // Packet ends early: short transfer, spare beat left on the stream
    clear_log();
    push_beat(8'hB1, 0); push_beat(8'hB2, 0); push_beat(8'hB3, 1); push_beat(8'hB4, 0);
    issue_cmd(32'h180, 16'd8, 0);
    wait_done(dc);
    check("t3_count", o_count, 3);
    check("t3_short", o_short, 1);
    check("t3_nwrites", wlog_a.size(), 3);
    tick();
    check("t3_beat_left", stream_q.size(), 1);

    // Address wrap; the leftover beat heads this transfer
    clear_log();
    push_beat(8'hC1, 0); push_beat(8'hC2, 0); push_beat(8'hC3, 1);
    issue_cmd(32'hFFFF_FFFE, 16'd4, 0);
    wait_done(dc);
    check("t4_count", o_count, 4);
    check("t4_short", o_short, 0);
    check("t4_nwrites", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      check("t4_addr1", wlog_a[1], 32'hFFFF_FFFF);
      check("t4_addr2", wlog_a[2], 32'h0);
      check("t4_addr3", wlog_a[3], 32'h1);
      check("t4_data0", wlog_d[0], 8'hB4);
    end

    // Zero-length command, then a command with cmd_valid held through the run
    clear_log();
    issue_cmd(32'h500, 16'd0, 0);
    wait_done(dc);
    check("t5_count0", o_count, 0);
    check("t5_short0", o_short, 0);
    check("t5_no_writes", wlog_a.size(), 0);
    push_beat(8'hE1, 0); push_beat(8'hE2, 0);
    issue_cmd(32'h40, 16'd2, 1);
    n = 0;
    while (!o_done && n < 50) begin
      check("t5_cmd_ready_busy", cmd_ready, 0);
      tick();
      n++;
    end
    check("t5_done_seen", o_done, 1);
    check("t5_count2", o_count, 2);
    cmd_valid = 1'b0;
    tick();
    tick();
    check("t5_nwrites", wlog_a.size(), 2);

    // Reset in the middle of a five-word transfer
    clear_log();
    push_beat(8'hD1, 0); push_beat(8'hD2, 0); push_beat(8'hD3, 0); push_beat(8'hD4, 0); push_beat(8'hD5, 1);
    issue_cmd(32'h200, 16'd5, 0);
    n = 0;
    while (wlog_a.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("t6_two_writes", wlog_a.size() >= 2, 1);
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_o_wvalid", o_wvalid, 0);
    check("t6_rst_cmd_ready", cmd_ready, 1);
    check("t6_rst_i_ready", i_ready, 0);
    check("t6_rst_o_done", o_done, 0);
    tick();
    tick();
    reset_n = 1'b1;
    clear_log();
    push_beat(8'hF1, 0); push_beat(8'hF2, 1);
    issue_cmd(32'h300, 16'd2, 0);
    wait_done(dc);
    check("t6_count", o_count, 2);
    check("t6_nwrites", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      check("t6_addr0", wlog_a[0], 32'h300);
      check("t6_data1", wlog_d[1], 8'hF2);
    end

    tick();
    tick();
    check("all_writes_seen", exp_w.size(), 0);
    check("all_dones_seen", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
